// File: rtl/vm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vm_pkg
// Description : Shared definitions for the coin payout controller: hopper
//               select encoding, coin values and the controller state type.
// Revision    : 1.0 - initial release
// ============================================================================
package vm_pkg;

    // Hopper / refill select encoding (value 3 is never driven)
    localparam logic [1:0] c_sel_1  = 2'd0;
    localparam logic [1:0] c_sel_5  = 2'd1;
    localparam logic [1:0] c_sel_10 = 2'd2;

    // Coin face values, sized to the 6-bit remaining-amount register
    localparam logic [5:0] c_val_1  = 6'd1;
    localparam logic [5:0] c_val_5  = 6'd5;
    localparam logic [5:0] c_val_10 = 6'd10;

    localparam int c_num_denom = 3;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SELECT   = 2'd1,
        ST_WAIT_ACK = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    // Face value of the coin ejected by a given hopper select
    function automatic logic [5:0] coin_value(input logic [1:0] sel);
        logic [5:0] v;
        v = 6'd0;
        case (sel)
            c_sel_1:  v = c_val_1;
            c_sel_5:  v = c_val_5;
            c_sel_10: v = c_val_10;
            default:  v = 6'd0;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/coin_inventory.sv
`default_nettype none
// ============================================================================
// Module      : coin_inventory
// Description : Saturating 8-bit coin counter for one denomination. Adds a
//               refill quantity and removes one coin per hopper ack, both in
//               the same cycle if needed, clamped at MAX_COUNT.
// Revision    : 1.0 - initial release
// ============================================================================
module coin_inventory #(
    parameter logic [7:0] INIT_COUNT = 8'd20,
    parameter logic [7:0] MAX_COUNT  = 8'd255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       refill_en,
    input  logic [7:0] refill_cnt,
    input  logic       dec_en,
    output logic [7:0] count
);

    logic [8:0] w_sum;

    // Next count at 9 bits so a refill overflow is seen before clamping.
    // A decrement is only requested for a coin that was in stock, so the
    // subtraction cannot wrap.
    always_comb begin
        w_sum = {1'b0, count}
              + (refill_en ? {1'b0, refill_cnt} : 9'd0)
              - {8'd0, dec_en};
    end

    // Counter register with saturation at MAX_COUNT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= INIT_COUNT;
        end else if (refill_en || dec_en) begin
            count <= (w_sum > {1'b0, MAX_COUNT}) ? MAX_COUNT : w_sum[7:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/coin_dispense_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : coin_dispense_ctrl
// Description : Greedy change-payout controller. Accepts an amount, ejects
//               10/5/1 coins one at a time through a handshaked hopper
//               interface, tracks per-denomination inventory and reports any
//               unpaid shortfall with a one-cycle done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module coin_dispense_ctrl
    import vm_pkg::*;
#(
    parameter logic [7:0] INIT_COUNT = 8'd20,
    parameter logic [7:0] MAX_COUNT  = 8'd255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    input  logic [5:0] req_amount,
    output logic       req_ready,
    output logic       coin_req,
    output logic [1:0] coin_sel,
    input  logic       coin_ack,
    output logic       done,
    output logic [5:0] shortfall,
    input  logic       refill,
    input  logic [1:0] refill_sel,
    input  logic [7:0] refill_cnt,
    output logic [7:0] inv_1,
    output logic [7:0] inv_5,
    output logic [7:0] inv_10
);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [5:0] r_remaining;
    logic [5:0] w_remaining_nxt;
    logic [1:0] w_coin_sel_nxt;
    logic [5:0] w_shortfall_nxt;
    logic       w_ack_take;
    logic [7:0] w_inv [c_num_denom];

    // An ack only counts while a coin is actually outstanding
    assign w_ack_take = (r_state == ST_WAIT_ACK) && coin_ack;

    generate
        for (genvar gi = 0; gi < c_num_denom; gi++) begin : g_inv
            coin_inventory #(
                .INIT_COUNT (INIT_COUNT),
                .MAX_COUNT  (MAX_COUNT)
            ) u_inv (
                .clk        (clk),
                .rst_n      (rst_n),
                .refill_en  (refill && (refill_sel == 2'(gi))),
                .refill_cnt (refill_cnt),
                .dec_en     (w_ack_take && (coin_sel == 2'(gi))),
                .count      (w_inv[gi])
            );
        end
    endgenerate

    assign inv_1  = w_inv[c_sel_1];
    assign inv_5  = w_inv[c_sel_5];
    assign inv_10 = w_inv[c_sel_10];

    // Next-state and next-output decode; SELECT decides on the registered
    // inventory, so a refill landing in that same cycle is not considered
    always_comb begin
        w_state_nxt     = r_state;
        w_remaining_nxt = r_remaining;
        w_coin_sel_nxt  = coin_sel;
        w_shortfall_nxt = shortfall;
        case (r_state)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    w_remaining_nxt = req_amount;
                    w_state_nxt     = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if ((r_remaining >= c_val_10) && (inv_10 != 8'd0)) begin
                    w_coin_sel_nxt = c_sel_10;
                    w_state_nxt    = ST_WAIT_ACK;
                end else if ((r_remaining >= c_val_5) && (inv_5 != 8'd0)) begin
                    w_coin_sel_nxt = c_sel_5;
                    w_state_nxt    = ST_WAIT_ACK;
                end else if ((r_remaining >= c_val_1) && (inv_1 != 8'd0)) begin
                    w_coin_sel_nxt = c_sel_1;
                    w_state_nxt    = ST_WAIT_ACK;
                end else begin
                    w_shortfall_nxt = r_remaining;
                    w_state_nxt     = ST_DONE;
                end
            end
            ST_WAIT_ACK: begin
                if (coin_ack) begin
                    w_remaining_nxt = r_remaining - coin_value(coin_sel);
                    w_state_nxt     = ST_SELECT;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, working amount and registered outputs; strobes follow the state
    // being entered so every output is a flop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_remaining <= 6'd0;
            req_ready   <= 1'b0;
            coin_req    <= 1'b0;
            coin_sel    <= c_sel_1;
            done        <= 1'b0;
            shortfall   <= 6'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_remaining <= w_remaining_nxt;
            req_ready   <= (w_state_nxt == ST_IDLE);
            coin_req    <= (w_state_nxt == ST_WAIT_ACK);
            coin_sel    <= w_coin_sel_nxt;
            done        <= (w_state_nxt == ST_DONE);
            shortfall   <= w_shortfall_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_coin_dispense_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_coin_dispense_ctrl
// Description : Self-checking bench for coin_dispense_ctrl with a
//               transaction-level greedy payout model and random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_coin_dispense_ctrl;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b1;
    logic       req_valid  = 1'b0;
    logic [5:0] req_amount = 6'd0;
    logic       coin_ack   = 1'b0;
    logic       refill     = 1'b0;
    logic [1:0] refill_sel = 2'd0;
    logic [7:0] refill_cnt = 8'd0;

    wire        a_ready, a_creq, a_done;
    wire [1:0]  a_sel;
    wire [5:0]  a_short;
    wire [7:0]  a_i1, a_i5, a_i10;
    wire        b_ready, b_creq, b_done;
    wire [1:0]  b_sel;
    wire [5:0]  b_short;
    wire [7:0]  b_i1, b_i5, b_i10;

    coin_dispense_ctrl u_dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_amount(req_amount),
        .req_ready(a_ready), .coin_req(a_creq), .coin_sel(a_sel), .coin_ack(coin_ack),
        .done(a_done), .shortfall(a_short), .refill(refill), .refill_sel(refill_sel),
        .refill_cnt(refill_cnt), .inv_1(a_i1), .inv_5(a_i5), .inv_10(a_i10)
    );

    coin_dispense_ctrl #(.INIT_COUNT(8'd0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_amount(req_amount),
        .req_ready(b_ready), .coin_req(b_creq), .coin_sel(b_sel), .coin_ack(coin_ack),
        .done(b_done), .shortfall(b_short), .refill(refill), .refill_sel(refill_sel),
        .refill_cnt(refill_cnt), .inv_1(b_i1), .inv_5(b_i5), .inv_10(b_i10)
    );

    always #5 clk = ~clk;

    // Observed view of whichever instance is under test
    bit         use_b = 1'b0;
    logic       ob_ready, ob_creq, ob_done;
    logic [1:0] ob_sel;
    logic [5:0] ob_short;
    logic [7:0] ob_inv [3];

    always_comb begin
        ob_ready  = use_b ? b_ready : a_ready;
        ob_creq   = use_b ? b_creq  : a_creq;
        ob_done   = use_b ? b_done  : a_done;
        ob_sel    = use_b ? b_sel   : a_sel;
        ob_short  = use_b ? b_short : a_short;
        ob_inv[0] = use_b ? b_i1    : a_i1;
        ob_inv[1] = use_b ? b_i5    : a_i5;
        ob_inv[2] = use_b ? b_i10   : a_i10;
    end

    // Reference model: inventory per denomination and coin face values
    int checks   = 0;
    int failures = 0;
    int m_inv [3];
    int m_init   = 20;
    int val   [3] = '{1, 5, 10};

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    // Greedy pick: largest coin that fits and is in stock, -1 if none
    function automatic int greedy(input int rem);
        for (int d = 2; d >= 0; d--)
            if (rem >= val[d] && m_inv[d] > 0) return d;
        return -1;
    endfunction

    // One clock: drive strobes, pass one rising edge, update the model
    task automatic drive_cycle(input bit ack, input int dec_sel, input bit rf,
                               input int rf_sel, input int rf_cnt);
        int m;
        coin_ack   = ack;
        refill     = rf;
        refill_sel = 2'(rf_sel);
        refill_cnt = 8'(rf_cnt);
        @(negedge clk);
        coin_ack = 1'b0;
        refill   = 1'b0;
        for (int d = 0; d < 3; d++) begin
            m = m_inv[d];
            if (rf && rf_sel == d) m = m + rf_cnt;
            if (dec_sel == d) m = m - 1;
            if (m > 255) m = 255;
            m_inv[d] = m;
        end
    endtask

    task automatic rnd_refill(output bit rf, output int rs, output int rc);
        rf = ($urandom_range(0, 2) == 0);
        rs = $urandom_range(0, 3);
        rc = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 4);
    endtask

    task automatic chk_inv(input string tag);
        for (int d = 0; d < 3; d++) chk(tag, ob_inv[d], m_inv[d]);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) m_inv[d] = m_init;
        chk("rst_ready", ob_ready, 0);
        chk("rst_creq", ob_creq, 0);
        chk("rst_sel", ob_sel, 0);
        chk("rst_done", ob_done, 0);
        chk("rst_short", ob_short, 0);
        chk_inv("rst_inv");
        rst_n = 1'b1;
        chk("ready_in_reset", ob_ready, 0);
        @(negedge clk);
        chk("ready_first_edge", ob_ready, 1);
    endtask

    // Full payout transaction: request, coin-by-coin greedy check, done
    task automatic payout(input int amt, input int dly, input bit rnd, input bit same_rf);
        int rem, exp_sel, rs, rc;
        bit rf, finished;
        rem      = amt;
        finished = 1'b0;
        chk("ready_before", ob_ready, 1);
        req_valid  = 1'b1;
        req_amount = 6'(amt);
        drive_cycle(0, -1, 0, 0, 0);
        req_valid = 1'b0;
        chk("ready_busy", ob_ready, 0);
        chk("no_early_req", ob_creq, 0);
        for (int n = 0; n < 80 && !finished; n++) begin
            exp_sel = greedy(rem);
            drive_cycle(0, -1, 0, 0, 0);
            if (exp_sel < 0) begin
                chk("done_pulse", ob_done, 1);
                chk("shortfall", ob_short, rem);
                chk("no_req_at_done", ob_creq, 0);
                finished = 1'b1;
            end else begin
                chk("coin_req", ob_creq, 1);
                chk("coin_sel", ob_sel, exp_sel);
                for (int k = 0; k < dly; k++) begin
                    rf = 1'b0; rs = 0; rc = 0;
                    if (rnd) rnd_refill(rf, rs, rc);
                    drive_cycle(0, -1, rf, rs, rc);
                    chk("hold_req", ob_creq, 1);
                    chk("hold_sel", ob_sel, exp_sel);
                end
                rf = 1'b0; rs = 0; rc = 0;
                if (rnd) rnd_refill(rf, rs, rc);
                if (same_rf) begin rf = 1'b1; rs = exp_sel; rc = 1; end
                drive_cycle(1, exp_sel, rf, rs, rc);
                chk("req_drop", ob_creq, 0);
                rem = rem - val[exp_sel];
            end
        end
        chk("payout_finished", finished, 1);
        drive_cycle(0, -1, 0, 0, 0);
        chk("done_one_cycle", ob_done, 0);
        chk("ready_after", ob_ready, 1);
        chk("short_held", ob_short, rem);
        chk_inv("inv_after");
    endtask

    initial begin
        int rs, rc, amt;
        bit rf;

        // Defaults on instance A
        use_b = 1'b0; m_init = 20;
        do_reset();

        // 16 -> 10, 5, 1 with a two-cycle ack delay
        payout(16, 2, 0, 0);
        chk("inv1_19", ob_inv[0], 19);
        chk("inv5_19", ob_inv[1], 19);
        chk("inv10_19", ob_inv[2], 19);

        // Zero request goes straight to done
        payout(0, 0, 0, 0);

        // Saturating refill, then refill+ack on the same denomination
        drive_cycle(0, -1, 1, 2, 250);
        chk("inv10_sat", ob_inv[2], 255);
        payout(5, 0, 0, 1);
        chk("inv5_unchanged", ob_inv[1], 19);

        // Long ack stall, then a stray ack while idle
        payout(12, 50, 0, 0);
        drive_cycle(1, -1, 0, 0, 0);
        chk("idle_ack_ready", ob_ready, 1);
        chk("idle_ack_creq", ob_creq, 0);
        chk_inv("idle_ack_inv");

        // Random traffic with refills and stray idle acks
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
                rnd_refill(rf, rs, rc);
                drive_cycle(bit'($urandom_range(0, 1)), -1, rf, rs, rc);
            end
            amt = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 63);
            payout(amt, $urandom_range(0, 4), 1, 0);
        end

        // Reset while waiting for an ack
        req_valid  = 1'b1;
        req_amount = 6'd30;
        drive_cycle(0, -1, 0, 0, 0);
        req_valid = 1'b0;
        drive_cycle(0, -1, 0, 0, 0);
        chk("pre_rst_creq", ob_creq, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_creq", ob_creq, 0);
        chk("async_ready", ob_ready, 0);
        chk("async_inv10", ob_inv[2], 20);
        chk("async_inv1", ob_inv[0], 20);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("no_done_after_rst", ob_done, 0);
        end

        // Instance B starts empty: refill three 5-coins, request 20
        use_b = 1'b1; m_init = 0;
        do_reset();
        drive_cycle(0, -1, 1, 1, 3);
        chk("b_inv5_3", ob_inv[1], 3);
        payout(20, 1, 0, 0);
        chk("b_short_5", ob_short, 5);
        chk("b_inv5_0", ob_inv[1], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time limit so the run always ends
    initial begin
        #2000000;
        failures++;
        $display("FAIL timeout: got running expected finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
